// File: rtl/frame_norm_req.sv
// frame_norm_req: buffers one frame of N signed samples, accumulates a
// saturating sum of squares, asks inv_sqrt for an inverse root, then streams
// every buffered sample scaled by that gain with round-half-up and clamping.
module frame_norm_req #(
  parameter int N   = 16,
  parameter int DW  = 16,
  parameter int SQW = 32,
  parameter int ISW = 10,
  parameter int SH  = 9,
  parameter int TMO = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   dv_i,
  input  logic signed [DW-1:0]   x_i,
  output logic                   rdy_o,
  output logic                   sq_dv_o,
  output logic [SQW-1:0]         sq_o,
  input  logic                   isrt_dv_i,
  input  logic [ISW-1:0]         isrt_i,
  output logic                   dv_o,
  output logic signed [DW-1:0]   y_o,
  output logic [$clog2(N)-1:0]   idx_o,
  output logic                   last_o,
  output logic                   err_o
);

  localparam int IW = $clog2(N);
  localparam int TW = $clog2(TMO);
  localparam int SW = ((SQW > 2*DW) ? SQW : 2*DW) + 1;
  localparam int PW = DW + ISW + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N-1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO-1);
  localparam logic signed [PW-1:0] RND  = PW'(1) << (SH-1);
  localparam logic signed [PW-1:0] YMAX = {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [PW-1:0] YMIN = ~YMAX;

  typedef enum logic [1:0] {S_ACC, S_REQ, S_WAIT, S_SCALE} state_t;

  state_t                r_state;
  logic [IW-1:0]         r_idx;
  logic [SQW-1:0]        r_acc;
  logic [TW-1:0]         r_timer;
  logic [ISW-1:0]        r_gain;
  logic [SQW-1:0]        r_sq;
  logic                  r_sq_dv;
  logic                  r_dv;
  logic signed [DW-1:0]  r_y;
  logic [IW-1:0]         r_oidx;
  logic                  r_last;
  logic                  r_err;
  logic signed [DW-1:0]  r_buf [N];

  logic signed [2*DW-1:0] w_sq;
  logic [SW-1:0]          w_sum;
  logic [SQW-1:0]         w_acc_nxt;
  logic signed [DW-1:0]   w_bs;
  logic signed [PW-1:0]   w_bx;
  logic signed [PW-1:0]   w_gx;
  logic signed [PW-1:0]   w_p;
  logic signed [PW-1:0]   w_pr;
  logic signed [PW-1:0]   w_sh;
  logic signed [DW-1:0]   w_y;

  // Square of the incoming sample is never negative, so it can be added as unsigned.
  assign w_sq      = x_i * x_i;
  assign w_sum     = {{(SW-SQW){1'b0}}, r_acc} + {{(SW-2*DW){1'b0}}, w_sq};
  assign w_acc_nxt = (|w_sum[SW-1:SQW]) ? {SQW{1'b1}} : w_sum[SQW-1:0];

  // Scaling path: signed sample times unsigned gain, round half up, shift, clamp.
  assign w_bs = r_buf[r_idx];
  assign w_bx = {{(ISW+1){w_bs[DW-1]}}, w_bs};
  assign w_gx = {{(DW+1){1'b0}}, r_gain};
  assign w_p  = w_bx * w_gx;
  assign w_pr = w_p + RND;
  assign w_sh = w_pr >>> SH;
  assign w_y  = (w_sh > YMAX) ? YMAX[DW-1:0] :
                (w_sh < YMIN) ? YMIN[DW-1:0] : w_sh[DW-1:0];

  assign rdy_o   = (r_state == S_ACC);
  assign sq_dv_o = r_sq_dv;
  assign sq_o    = r_sq;
  assign dv_o    = r_dv;
  assign y_o     = r_y;
  assign idx_o   = r_oidx;
  assign last_o  = r_last;
  assign err_o   = r_err;

  // Sample store: contents are don't-care after reset, so it carries no reset.
  always_ff @(posedge clk) begin
    if (r_state == S_ACC && dv_i) r_buf[r_idx] <= x_i;
  end

  // Frame control: accumulate, request, wait with timeout, then stream scaled samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_ACC;
      r_idx   <= '0;
      r_acc   <= '0;
      r_timer <= '0;
      r_gain  <= '0;
      r_sq    <= '0;
      r_sq_dv <= 1'b0;
      r_dv    <= 1'b0;
      r_y     <= '0;
      r_oidx  <= '0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_sq_dv <= 1'b0;
      r_dv    <= 1'b0;
      r_last  <= 1'b0;
      case (r_state)
        S_ACC: begin
          if (dv_i) begin
            r_acc <= w_acc_nxt;
            if (r_idx == LAST_IDX) begin
              r_idx <= '0;
              if (w_acc_nxt == '0) begin
                r_gain  <= '0;
                r_state <= S_SCALE;
              end else begin
                r_sq    <= w_acc_nxt;
                r_sq_dv <= 1'b1;
                r_state <= S_REQ;
              end
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        S_REQ: begin
          r_timer <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (isrt_dv_i) begin
            r_gain  <= isrt_i;
            r_state <= S_SCALE;
          end else if (r_timer == TMO_LAST) begin
            r_err   <= 1'b1;
            r_gain  <= '0;
            r_state <= S_SCALE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_SCALE: begin
          r_dv   <= 1'b1;
          r_y    <= w_y;
          r_oidx <= r_idx;
          r_last <= (r_idx == LAST_IDX);
          if (r_idx == LAST_IDX) begin
            r_idx   <= '0;
            r_acc   <= '0;
            r_state <= S_ACC;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: r_state <= S_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_norm_req.sv
// tb_frame_norm_req: directed and random frames against an arithmetic
// reference model, with an inv_sqrt stub whose reply delay is programmable.
module tb_frame_norm_req;

  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int SQW = 32;
  localparam int ISW = 10;
  localparam int SH  = 9;
  localparam int TMO = 64;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  dv_i = 1'b0;
  logic signed [DW-1:0]  x_i = '0;
  logic                  rdy_o;
  logic                  sq_dv_o;
  logic [SQW-1:0]        sq_o;
  logic                  isrt_dv_i = 1'b0;
  logic [ISW-1:0]        isrt_i = '0;
  logic                  dv_o;
  logic signed [DW-1:0]  y_o;
  logic [$clog2(N)-1:0]  idx_o;
  logic                  last_o;
  logic                  err_o;

  frame_norm_req #(.N(N), .DW(DW), .SQW(SQW), .ISW(ISW), .SH(SH), .TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .dv_i(dv_i), .x_i(x_i), .rdy_o(rdy_o),
    .sq_dv_o(sq_dv_o), .sq_o(sq_o), .isrt_dv_i(isrt_dv_i), .isrt_i(isrt_i),
    .dv_o(dv_o), .y_o(y_o), .idx_o(idx_o), .last_o(last_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;

  logic signed [DW-1:0] frame [N];

  logic signed [DW-1:0] outY [$];
  int                   outIdx [$];
  int                   outLast [$];
  int                   outCyc [$];
  int                   sqCount = 0;
  int                   sqCyc = -1;
  logic [SQW-1:0]       sqVal = '0;
  int                   firstOutCyc = -1;
  int                   errRiseCyc = -1;
  int                   replyCyc = -1;
  int                   lastInCyc = -1;
  bit                   errPrev = 1'b0;

  int                   stubDelay = 1;
  bit                   stubEn = 1'b0;
  logic [ISW-1:0]       stubVal = '0;

  // Monitor: samples DUT outputs 1 time unit after each rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (sq_dv_o) begin
      sqCount++;
      sqVal = sq_o;
      sqCyc = cyc;
    end
    if (dv_o) begin
      outY.push_back(y_o);
      outIdx.push_back(int'(idx_o));
      outLast.push_back(int'(last_o));
      outCyc.push_back(cyc);
      if (firstOutCyc < 0) firstOutCyc = cyc;
    end
    if (err_o && !errPrev) errRiseCyc = cyc;
    errPrev = err_o;
  end

  // inv_sqrt stub: a delay of d places the reply in the d-th WAIT cycle.
  initial forever begin
    @(negedge clk);
    if (sq_dv_o && stubEn) begin
      automatic int d = stubDelay;
      automatic logic [ISW-1:0] v = stubVal;
      repeat (d) @(negedge clk);
      isrt_i = v;
      isrt_dv_i = 1'b1;
      replyCyc = cyc;
      @(negedge clk);
      isrt_dv_i = 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Reference: exact sum of squares, clipped at the top of the SQW range.
  function automatic longint refSumSq();
    longint s = 0;
    longint cap = (longint'(1) <<< SQW) - 1;
    for (int i = 0; i < N; i++) s += longint'(frame[i]) * longint'(frame[i]);
    return (s > cap) ? cap : s;
  endfunction

  // Reference: floor((x*g + half) / 2^SH), clamped to the signed DW range.
  function automatic longint refY(input longint x, input longint g);
    longint q = (x * g + (longint'(1) <<< (SH-1))) >>> SH;
    longint hi = (longint'(1) <<< (DW-1)) - 1;
    longint lo = -(longint'(1) <<< (DW-1));
    if (q > hi) return hi;
    if (q < lo) return lo;
    return q;
  endfunction

  task automatic setFrame(input int a, input int b, input int c, input int d);
    frame[0] = DW'(a);
    frame[1] = DW'(b);
    frame[2] = DW'(c);
    frame[3] = DW'(d);
  endtask

  task automatic applyStimulus(input bit gaps);
    for (int i = 0; i < N; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          dv_i = 1'b0;
        end
      end
      @(negedge clk);
      dv_i = 1'b1;
      x_i = frame[i];
      if (i == N-1) lastInCyc = cyc;
    end
  endtask

  task automatic runFrame(input string name, input int delay, input bit replyEn,
                          input logic [ISW-1:0] gain, input bit junk, input bit gaps);
    longint sum;
    bit reqExp, replyUsed, timeoutExp, errBefore;
    longint gainExp;
    int waited;
    outY.delete(); outIdx.delete(); outLast.delete(); outCyc.delete();
    sqCount = 0; sqCyc = -1; firstOutCyc = -1; errRiseCyc = -1; replyCyc = -1;
    stubDelay = delay; stubEn = replyEn; stubVal = gain;
    errBefore = err_o;
    sum = refSumSq();
    reqExp = (sum != 0);
    replyUsed = reqExp && replyEn && delay >= 1 && delay <= TMO;
    timeoutExp = reqExp && !replyUsed;
    gainExp = replyUsed ? longint'(gain) : 0;

    applyStimulus(gaps);
    waited = 0;
    while (outY.size() < N && waited < 300) begin
      @(negedge clk);
      dv_i = junk && !rdy_o;
      if (junk) x_i = DW'($urandom);
      waited++;
    end
    repeat (4) begin
      @(negedge clk);
      dv_i = 1'b0;
    end

    checkOutput({name, ".out_count"}, outY.size(), N);
    checkOutput({name, ".sq_pulses"}, sqCount, reqExp ? 1 : 0);
    if (reqExp) begin
      checkOutput({name, ".sq_val"}, longint'(sqVal), sum);
      checkOutput({name, ".sq_hold"}, longint'(sq_o), sum);
      checkOutput({name, ".sq_latency"}, sqCyc - lastInCyc, 1);
    end else begin
      checkOutput({name, ".zero_latency"}, firstOutCyc - lastInCyc, 2);
    end
    if (replyUsed) checkOutput({name, ".reply_latency"}, firstOutCyc - replyCyc, 2);
    if (timeoutExp && !errBefore) begin
      // REQ in cycle k, WAIT cycles k+1..k+TMO, flag visible in k+TMO+1.
      checkOutput({name, ".err_latency"}, errRiseCyc - sqCyc, TMO + 1);
      checkOutput({name, ".tmo_first_out"}, firstOutCyc - sqCyc, TMO + 2);
    end
    checkOutput({name, ".err"}, longint'(err_o), (errBefore || timeoutExp) ? 1 : 0);
    for (int i = 0; i < outY.size(); i++) begin
      checkOutput($sformatf("%s.y%0d", name, i), longint'(outY[i]), refY(longint'(frame[i]), gainExp));
      checkOutput($sformatf("%s.idx%0d", name, i), outIdx[i], i);
      checkOutput($sformatf("%s.last%0d", name, i), outLast[i], (i == N-1) ? 1 : 0);
      checkOutput($sformatf("%s.gap%0d", name, i), outCyc[i] - outCyc[0], i);
    end
    checkOutput({name, ".rdy_after"}, longint'(rdy_o), 1);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset.rdy", longint'(rdy_o), 1);
    checkOutput("reset.sq_dv", longint'(sq_dv_o), 0);
    checkOutput("reset.sq", longint'(sq_o), 0);
    checkOutput("reset.dv", longint'(dv_o), 0);
    checkOutput("reset.y", longint'(y_o), 0);
    checkOutput("reset.idx", longint'(idx_o), 0);
    checkOutput("reset.last", longint'(last_o), 0);
    checkOutput("reset.err", longint'(err_o), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic frame, reply after 5 cycles
    setFrame(300, 400, 0, 0);
    runFrame("t1", 5, 1'b1, 10'd256, 1'b0, 1'b0);

    // Rounding in both directions at exact halves
    setFrame(-3, 3, -1, 1);
    runFrame("t2", 3, 1'b1, 10'd256, 1'b0, 1'b0);

    // Output clamping; this sum lands just under the accumulator ceiling
    setFrame(32767, -32768, -32768, -32768);
    runFrame("t3", 2, 1'b1, 10'd1023, 1'b0, 1'b0);

    // Accumulator saturation, dv_i held high while busy
    setFrame(-32768, -32768, -32768, -32768);
    runFrame("sat", 4, 1'b1, 10'd512, 1'b1, 1'b0);

    // All-zero frame skips the request
    setFrame(0, 0, 0, 0);
    runFrame("t4", 3, 1'b1, 10'd100, 1'b0, 1'b0);

    // Random frames
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 1) == 0) frame[i] = DW'(int'($urandom_range(0, 600)) - 300);
        else frame[i] = DW'($urandom);
      end
      runFrame($sformatf("rnd%0d", r), int'($urandom_range(1, 20)), 1'b1,
               ISW'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)), 1'b1);
    end

    // Timeout; the late reply lands after the frame and must be ignored
    setFrame(1000, -2000, 3000, -4000);
    runFrame("t5a", 70, 1'b1, 10'd300, 1'b1, 1'b0);

    // Normal frame after a timeout: error flag stays set
    setFrame(5000, -6000, 7000, -8000);
    runFrame("t5b", 8, 1'b1, 10'd700, 1'b0, 1'b1);

    // Reply on the very cycle the timeout would fire wins
    setFrame(-1234, 2345, -3456, 4567);
    runFrame("t5c", TMO, 1'b1, 10'd900, 1'b0, 1'b0);

    // Reset in the middle of a frame, then a fresh frame
    @(negedge clk); dv_i = 1'b1; x_i = 16'sd9999;
    @(negedge clk); dv_i = 1'b1; x_i = -16'sd9999;
    @(negedge clk); dv_i = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    checkOutput("t6.err_cleared", longint'(err_o), 0);
    checkOutput("t6.rdy", longint'(rdy_o), 1);
    rst_n = 1'b1;
    @(negedge clk);
    setFrame(111, -222, 333, -444);
    runFrame("t6", 6, 1'b1, 10'd600, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
